// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: instruction fields, memory handshake and datapath control strobes of the multicycle controller
interface multicycle_ctrl_if;
   logic [1:0] Op;
   logic [5:0] Funct;
   logic [3:0] Rd;
   logic       CondEx;
   logic       mem_ready;
   logic       mem_req;
   logic       AdrSrc;
   logic       MemW;
   logic       IRWrite;
   logic       PCWrite;
   logic       RegW;
   logic       linkSelect;
   logic       ALUSrcA;
   logic [1:0] ALUSrcB;
   logic [1:0] ResultSrc;
   logic       ALUOp;
   logic       instr_done;
   logic       fault;
   logic [3:0] state;
   modport master (
      input  Op, Funct, Rd, CondEx, mem_ready,
      output mem_req, AdrSrc, MemW, IRWrite, PCWrite, RegW, linkSelect,
             ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, fault, state
   );
   modport slave (
      output Op, Funct, Rd, CondEx, mem_ready,
      input  mem_req, AdrSrc, MemW, IRWrite, PCWrite, RegW, linkSelect,
             ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done, fault, state
   );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: FSM stepping each SimpleARM instruction through fetch/decode/execute/memory/writeback with a memory wait-state timeout
module multicycle_ctrl #(
   parameter int TIMEOUT = 255
) (
   input logic               clk,
   input logic               reset_n,
   multicycle_ctrl_if.master bus
);
   typedef enum logic [3:0] {
      FETCH  = 4'd0,
      DECODE = 4'd1,
      MEMADR = 4'd2,
      MEMRD  = 4'd3,
      MEMWB  = 4'd4,
      MEMWR  = 4'd5,
      EXECR  = 4'd6,
      EXECI  = 4'd7,
      ALUWB  = 4'd8,
      BRANCH = 4'd9,
      FAULT  = 4'd15
   } state_e;
   localparam logic [7:0] TO = 8'(TIMEOUT);
   state_e     state_q, state_d;
   logic [7:0] cnt_q, cnt_d, cnt_inc;
   logic       fault_q, fault_d;
   logic       mem_st, cmp_op, rd_pc;
   logic       mem_req, adr_src, mem_w, ir_write, pc_write, reg_w, link_sel, src_a, alu_op, done;
   logic [1:0] src_b, res_src;
   logic       unused;
   assign unused  = ^bus.Funct[2:1];
   assign mem_st  = state_q inside {FETCH, MEMRD, MEMWR};
   assign cmp_op  = bus.Funct[4:3] == 2'b10;
   assign rd_pc   = bus.Rd == 4'hF;
   assign cnt_inc = cnt_q + 8'd1;
   always_comb begin
      state_d  = state_q;
      mem_req  = 1'b0;
      adr_src  = 1'b0;
      mem_w    = 1'b0;
      ir_write = 1'b0;
      pc_write = 1'b0;
      reg_w    = 1'b0;
      link_sel = 1'b0;
      src_a    = 1'b0;
      src_b    = 2'd0;
      res_src  = 2'd0;
      alu_op   = 1'b0;
      done     = 1'b0;
      case (state_q)
         FETCH: begin
            mem_req = 1'b1;
            if (bus.mem_ready) begin
               ir_write = 1'b1;
               pc_write = 1'b1;
               src_a    = 1'b1;
               src_b    = 2'd2;
               res_src  = 2'd2;
               state_d  = DECODE;
            end
         end
         DECODE: begin
            src_a = 1'b1;
            src_b = 2'd2;
            if (!bus.CondEx) begin
               state_d = FETCH;
               done    = 1'b1;
            end else if (bus.Op == 2'b00) state_d = bus.Funct[5] ? EXECI : EXECR;
            else if (bus.Op == 2'b01) state_d = MEMADR;
            else state_d = BRANCH;
         end
         EXECR, EXECI: begin
            alu_op  = 1'b1;
            src_b   = (state_q == EXECI) ? 2'd1 : 2'd0;
            state_d = cmp_op ? FETCH : ALUWB;
            done    = cmp_op;
         end
         ALUWB: begin
            reg_w    = 1'b1;
            pc_write = rd_pc;
            state_d  = FETCH;
            done     = 1'b1;
         end
         MEMADR: begin
            src_b   = 2'd1;
            state_d = bus.Funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            if (bus.mem_ready) state_d = MEMWB;
         end
         MEMWB: begin
            res_src  = 2'd1;
            reg_w    = 1'b1;
            pc_write = rd_pc;
            state_d  = FETCH;
            done     = 1'b1;
         end
         MEMWR: begin
            mem_req = 1'b1;
            adr_src = 1'b1;
            mem_w   = 1'b1;
            if (bus.mem_ready) begin
               state_d = FETCH;
               done    = 1'b1;
            end
         end
         BRANCH: begin
            src_b    = 2'd1;
            res_src  = 2'd2;
            pc_write = 1'b1;
            reg_w    = bus.Op == 2'b11;
            link_sel = bus.Op == 2'b11;
            state_d  = FETCH;
            done     = 1'b1;
         end
         FAULT: state_d = FAULT;
         default: state_d = FETCH;
      endcase
      // TIMEOUT-th consecutive wait cycle without ready abandons the access
      if (mem_st && !bus.mem_ready && cnt_inc == TO) state_d = FAULT;
      cnt_d   = (mem_st && !bus.mem_ready && state_d == state_q) ? cnt_inc : 8'd0;
      fault_d = fault_q | (state_d == FAULT);
   end
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= FETCH;
         cnt_q   <= 8'd0;
         fault_q <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         fault_q <= fault_d;
      end
   end
   // strobes are forced low combinationally so an asserting reset aborts an access immediately
   assign bus.mem_req    = reset_n & mem_req;
   assign bus.AdrSrc     = reset_n & adr_src;
   assign bus.MemW       = reset_n & mem_w;
   assign bus.IRWrite    = reset_n & ir_write;
   assign bus.PCWrite    = reset_n & pc_write;
   assign bus.RegW       = reset_n & reg_w;
   assign bus.linkSelect = reset_n & link_sel;
   assign bus.ALUSrcA    = reset_n & src_a;
   assign bus.ALUSrcB    = reset_n ? src_b : 2'd0;
   assign bus.ResultSrc  = reset_n ? res_src : 2'd0;
   assign bus.ALUOp      = reset_n & alu_op;
   assign bus.instr_done = reset_n & done;
   assign bus.fault      = reset_n & fault_q;
   assign bus.state      = state_q;
endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb_multicycle_ctrl: cycle-by-cycle vector table plus hand sequences for timeout and reset aborts
module tb_multicycle_ctrl;
   logic clk = 1'b0;
   logic reset_n = 1'b0;
   int   checks = 0;
   int   failures = 0;
   multicycle_ctrl_if b();
   multicycle_ctrl #(.TIMEOUT(4)) dut (.clk(clk), .reset_n(reset_n), .bus(b));
   always #5 clk = ~clk;
   // {mem_req, AdrSrc, MemW, IRWrite, PCWrite, RegW, linkSelect, ALUSrcA, ALUSrcB, ResultSrc, ALUOp, instr_done}
   localparam logic [13:0] C_ZERO   = 14'b0_0_0_0_0_0_0_0_00_00_0_0;
   localparam logic [13:0] C_F_WAIT = 14'b1_0_0_0_0_0_0_0_00_00_0_0;
   localparam logic [13:0] C_F_GO   = 14'b1_0_0_1_1_0_0_1_10_10_0_0;
   localparam logic [13:0] C_DEC    = 14'b0_0_0_0_0_0_0_1_10_00_0_0;
   localparam logic [13:0] C_DEC_D  = 14'b0_0_0_0_0_0_0_1_10_00_0_1;
   localparam logic [13:0] C_XR     = 14'b0_0_0_0_0_0_0_0_00_00_1_0;
   localparam logic [13:0] C_XR_C   = 14'b0_0_0_0_0_0_0_0_00_00_1_1;
   localparam logic [13:0] C_XI     = 14'b0_0_0_0_0_0_0_0_01_00_1_0;
   localparam logic [13:0] C_XI_C   = 14'b0_0_0_0_0_0_0_0_01_00_1_1;
   localparam logic [13:0] C_AWB    = 14'b0_0_0_0_0_1_0_0_00_00_0_1;
   localparam logic [13:0] C_AWB_PC = 14'b0_0_0_0_1_1_0_0_00_00_0_1;
   localparam logic [13:0] C_MADR   = 14'b0_0_0_0_0_0_0_0_01_00_0_0;
   localparam logic [13:0] C_MRD    = 14'b1_1_0_0_0_0_0_0_00_00_0_0;
   localparam logic [13:0] C_MWB    = 14'b0_0_0_0_0_1_0_0_00_01_0_1;
   localparam logic [13:0] C_MWB_PC = 14'b0_0_0_0_1_1_0_0_00_01_0_1;
   localparam logic [13:0] C_MWR    = 14'b1_1_1_0_0_0_0_0_00_00_0_0;
   localparam logic [13:0] C_MWR_D  = 14'b1_1_1_0_0_0_0_0_00_00_0_1;
   localparam logic [13:0] C_BL     = 14'b0_0_0_0_1_1_1_0_01_10_0_1;
   localparam logic [13:0] C_B      = 14'b0_0_0_0_1_0_0_0_01_10_0_1;
   typedef struct {
      logic [1:0]  op;
      logic [5:0]  funct;
      logic [3:0]  rd;
      logic        cond;
      logic        rdy;
      logic [3:0]  st;
      logic [13:0] ctl;
   } vec_t;
   vec_t        tbl[$];
   logic [13:0] ctl_w;
   assign ctl_w = {b.mem_req, b.AdrSrc, b.MemW, b.IRWrite, b.PCWrite, b.RegW, b.linkSelect,
                   b.ALUSrcA, b.ALUSrcB, b.ResultSrc, b.ALUOp, b.instr_done};
   task automatic add(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                      input logic cond, input logic rdy, input logic [3:0] st, input logic [13:0] ctl);
      vec_t v;
      v.op = op; v.funct = funct; v.rd = rd; v.cond = cond; v.rdy = rdy; v.st = st; v.ctl = ctl;
      tbl.push_back(v);
   endtask
   task automatic drive(input logic [1:0] op, input logic [5:0] funct, input logic [3:0] rd,
                        input logic cond, input logic rdy);
      b.Op = op; b.Funct = funct; b.Rd = rd; b.CondEx = cond; b.mem_ready = rdy;
   endtask
   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h", nm, got, exp);
      end
   endtask
   task automatic tick();
      @(posedge clk);
      #1;
   endtask
   initial begin
      // ADD r3 (register), CondEx/mem_ready toggled where they must be ignored
      add(2'b00, 6'b001000, 4'd3, 1, 1, 4'd0, C_F_GO);
      add(2'b00, 6'b001000, 4'd3, 1, 1, 4'd1, C_DEC);
      add(2'b00, 6'b001000, 4'd3, 0, 0, 4'd6, C_XR);
      add(2'b00, 6'b001000, 4'd3, 0, 0, 4'd8, C_AWB);
      // LDR pc with two wait states
      add(2'b01, 6'b000001, 4'hF, 0, 1, 4'd0, C_F_GO);
      add(2'b01, 6'b000001, 4'hF, 1, 0, 4'd1, C_DEC);
      add(2'b01, 6'b000001, 4'hF, 1, 1, 4'd2, C_MADR);
      add(2'b01, 6'b000001, 4'hF, 1, 0, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'hF, 1, 0, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'hF, 1, 1, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'hF, 1, 1, 4'd4, C_MWB_PC);
      // CMP immediate
      add(2'b00, 6'b110101, 4'd0, 1, 1, 4'd0, C_F_GO);
      add(2'b00, 6'b110101, 4'd0, 1, 1, 4'd1, C_DEC);
      add(2'b00, 6'b110101, 4'd0, 1, 1, 4'd7, C_XI_C);
      // BL taken, then B with condition failing
      add(2'b11, 6'b000000, 4'd0, 1, 1, 4'd0, C_F_GO);
      add(2'b11, 6'b000000, 4'd0, 1, 1, 4'd1, C_DEC);
      add(2'b11, 6'b000000, 4'd0, 1, 1, 4'd9, C_BL);
      add(2'b10, 6'b000000, 4'd0, 1, 1, 4'd0, C_F_GO);
      add(2'b10, 6'b000000, 4'd0, 0, 1, 4'd1, C_DEC_D);
      // STR with one fetch wait state
      add(2'b01, 6'b000000, 4'd2, 1, 0, 4'd0, C_F_WAIT);
      add(2'b01, 6'b000000, 4'd2, 1, 1, 4'd0, C_F_GO);
      add(2'b01, 6'b000000, 4'd2, 1, 1, 4'd1, C_DEC);
      add(2'b01, 6'b000000, 4'd2, 1, 1, 4'd2, C_MADR);
      add(2'b01, 6'b000000, 4'd2, 1, 1, 4'd5, C_MWR_D);
      // MOV pc, #imm
      add(2'b00, 6'b111010, 4'hF, 1, 1, 4'd0, C_F_GO);
      add(2'b00, 6'b111010, 4'hF, 1, 1, 4'd1, C_DEC);
      add(2'b00, 6'b111010, 4'hF, 1, 1, 4'd7, C_XI);
      add(2'b00, 6'b111010, 4'hF, 1, 1, 4'd8, C_AWB_PC);
      // B taken
      add(2'b10, 6'b000000, 4'd0, 1, 1, 4'd0, C_F_GO);
      add(2'b10, 6'b000000, 4'd0, 1, 1, 4'd1, C_DEC);
      add(2'b10, 6'b000000, 4'd0, 1, 1, 4'd9, C_B);
      // CMP register
      add(2'b00, 6'b010101, 4'd0, 1, 1, 4'd0, C_F_GO);
      add(2'b00, 6'b010101, 4'd0, 1, 1, 4'd1, C_DEC);
      add(2'b00, 6'b010101, 4'd0, 1, 1, 4'd6, C_XR_C);
      // LDR r2, ready arrives on the last allowed cycle
      add(2'b01, 6'b000001, 4'd2, 1, 1, 4'd0, C_F_GO);
      add(2'b01, 6'b000001, 4'd2, 1, 1, 4'd1, C_DEC);
      add(2'b01, 6'b000001, 4'd2, 1, 1, 4'd2, C_MADR);
      add(2'b01, 6'b000001, 4'd2, 1, 0, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'd2, 1, 0, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'd2, 1, 0, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'd2, 1, 1, 4'd3, C_MRD);
      add(2'b01, 6'b000001, 4'd2, 1, 1, 4'd4, C_MWB);
      drive(2'b00, 6'b001000, 4'd3, 1, 1);
      repeat (2) @(posedge clk);
      @(negedge clk);
      chk("reset_state", {b.state, b.fault, ctl_w}, {4'd0, 1'b0, C_ZERO});
      tick();
      reset_n = 1'b1;
      foreach (tbl[i]) begin
         drive(tbl[i].op, tbl[i].funct, tbl[i].rd, tbl[i].cond, tbl[i].rdy);
         @(negedge clk);
         chk($sformatf("row%0d", i), {b.state, b.fault, ctl_w}, {tbl[i].st, 1'b0, tbl[i].ctl});
         tick();
      end
      // STR that never gets ready: four wait cycles then FAULT
      drive(2'b01, 6'b000000, 4'd1, 1, 1);
      tick();
      tick();
      tick();
      b.mem_ready = 1'b0;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         chk($sformatf("to_wait%0d", k), {b.state, b.fault, b.MemW}, {4'd5, 1'b0, 1'b1});
         tick();
      end
      @(negedge clk);
      chk("to_fault", {b.state, b.fault, ctl_w}, {4'd15, 1'b1, C_ZERO});
      b.mem_ready = 1'b1;
      tick();
      @(negedge clk);
      chk("fault_sticky", {b.state, b.fault, ctl_w}, {4'd15, 1'b1, C_ZERO});
      reset_n = 1'b0;
      #1;
      chk("fault_reset", {b.state, b.fault, ctl_w}, {4'd0, 1'b0, C_ZERO});
      tick();
      reset_n = 1'b1;
      @(negedge clk);
      chk("post_reset", {b.state, b.fault, ctl_w}, {4'd0, 1'b0, C_F_GO});
      // reset asserted mid-MEMWR
      tick();
      tick();
      tick();
      b.mem_ready = 1'b0;
      @(negedge clk);
      chk("mwr_pre", {b.state, ctl_w}, {4'd5, C_MWR});
      #2;
      reset_n = 1'b0;
      #1;
      chk("mwr_abort", {b.state, b.fault, ctl_w}, {4'd0, 1'b0, C_ZERO});
      tick();
      chk("mwr_held", {b.state, b.fault, ctl_w}, {4'd0, 1'b0, C_ZERO});
      reset_n = 1'b1;
      @(negedge clk);
      chk("restart_wait", {b.state, ctl_w}, {4'd0, C_F_WAIT});
      b.mem_ready = 1'b1;
      #1;
      chk("restart_go", {b.state, ctl_w}, {4'd0, C_F_GO});
      tick();
      @(negedge clk);
      chk("restart_decode", {b.state, ctl_w}, {4'd1, C_DEC});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
